reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
//  Architectural register file plus rename-tag table for the Tomasulo core. Sits directly
//  downstream of the reorder buffer: consumes its in-order commits (rd, ROB tag, value)
//  and its mispredict flush. Serves the decoder/dispatch stage with operand values or
//  producing ROB tags, and records new renames at dispatch.
// PARAMETERS
//  XLEN      32  data width of each register
//  REG_W     5   register index width (32 architectural regs, x0 hard-wired zero)
//  ROB_W     4   ROB tag width (16-entry ROB)
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  rst         in   1      synchronous reset, active-low (rst==0 resets at posedge)
//  rdy         in   1      global ready; rdy==0 freezes all state (reset still wins)
//  flush       in   1      mispredict flush from ROB (its jump_wrong)
//  q1_idx      in   REG_W  source-1 register index from decoder
//  q2_idx      in   REG_W  source-2 register index from decoder
//  q1_busy     out  1      1: source-1 pending, use q1_tag; 0: q1_val valid
//  q1_tag      out  ROB_W  ROB tag producing source 1 (0 when not busy)
//  q1_val      out  XLEN   source-1 value (0 when busy)
//  q2_busy/q2_tag/q2_val   out  as above for source 2
//  rn_en       in   1      dispatch renames rn_rd to rn_tag this cycle
//  rn_rd       in   REG_W  destination register being renamed
//  rn_tag      in   ROB_W  ROB entry allocated to that instruction
//  cm_en       in   1      ROB commits a register-writing instruction this cycle
//  cm_rd       in   REG_W  committed destination register
//  cm_tag      in   ROB_W  ROB tag of the committing entry
//  cm_val      in   XLEN   committed result
//  commit_cnt  out  32     number of accepted commits with cm_rd!=0, wraps mod 2^32
// BEHAVIOUR
//  State: val[0..31], busy[0..31], tag[0..31], commit_cnt; all registered.
//  Reset (rst==0 at posedge): val=0, busy=0, tag=0, commit_cnt=0 for every entry;
//   from the following cycle all q*_busy=0, q*_tag=0, q*_val=0.
//  rdy==0 and rst==1: no state change; queries still answer combinationally.
//  Commit (cm_en, cm_rd!=0): val[cm_rd]<=cm_val; commit_cnt++;
//   busy[cm_rd]<=0 only if tag[cm_rd]==cm_tag (no younger rename outstanding).
//  Rename (rn_en, rn_rd!=0, no flush): busy[rn_rd]<=1, tag[rn_rd]<=rn_tag.
//  Same rd renamed and committed in one cycle: value written, rename wins busy/tag.
//  Flush: busy[*]<=0 for all regs; rn_en ignored; a same-cycle commit still writes
//   val and counts (it is the last valid instruction). Tags left as-is, unused.
//  x0: never written, never busy; queries of x0 return busy=0, tag=0, val=0.
//  Query (combinational, 0 cycle latency), per source s with index i:
//   if busy[i] && cm_en && cm_rd==i && cm_tag==tag[i]: bypass -> busy=0, val=cm_val.
//   else if busy[i]: busy=1, tag=tag[i], val=0.   else: busy=0, tag=0, val=val[i].
//  Queries see state before this cycle's rename (instr reading and writing the same
//   reg gets the old mapping). No bypass applied during flush-free rename of same reg.
//  commit_cnt: 32-bit unsigned, 0xFFFF_FFFF + 1 -> 0.
// TESTING
//  1 Reset: rst=0 one cycle after random state -> all 32 queries busy=0,val=0; cnt=0.
//  2 rn x5->tag 3; next cycle q1_idx=5 -> busy=1,tag=3; cm x5 tag3 val 0xDEAD_BEEF
//    same cycle -> q1 busy=0,val=0xDEADBEEF; next cycle stored, busy=0, cnt=1.
//  3 rn x7->tag2, rn x7->tag6; commit x7 tag2 val 11 -> val[7]=11 but q busy=1,tag=6.
//  4 Same cycle rn x9->tag4 and cm x9 tag1 val 5 -> val[9]=5, busy=1, tag=4.
//  5 Busy x1..x31, flush with cm x3 tag t val 42 and rn x8 -> all busy=0, x3=42,
//    x8 untouched; writes/renames to x0 -> x0 reads 0, not busy, cnt unchanged.
//  6 rdy=0 with rn/cm asserted -> no change; preload cnt=0xFFFF_FFFF, one commit -> 0.

Source files
------------

// File: rtl/reg_rename_file_if.sv
// rtl/reg_rename_file_if.sv - dispatch/commit/query bundle between ROB, decoder and rename file
interface reg_rename_file_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int ROB_W = 4
);
  logic             rdy;
  logic             flush;
  logic [REG_W-1:0] q1_idx;
  logic [REG_W-1:0] q2_idx;
  logic             q1_busy;
  logic [ROB_W-1:0] q1_tag;
  logic [XLEN-1:0]  q1_val;
  logic             q2_busy;
  logic [ROB_W-1:0] q2_tag;
  logic [XLEN-1:0]  q2_val;
  logic             rn_en;
  logic [REG_W-1:0] rn_rd;
  logic [ROB_W-1:0] rn_tag;
  logic             cm_en;
  logic [REG_W-1:0] cm_rd;
  logic [ROB_W-1:0] cm_tag;
  logic [XLEN-1:0]  cm_val;
  logic [31:0]      commit_cnt;

  modport master (
    output rdy, flush, q1_idx, q2_idx, rn_en, rn_rd, rn_tag,
           cm_en, cm_rd, cm_tag, cm_val,
    input  q1_busy, q1_tag, q1_val, q2_busy, q2_tag, q2_val, commit_cnt
  );

  modport slave (
    input  rdy, flush, q1_idx, q2_idx, rn_en, rn_rd, rn_tag,
           cm_en, cm_rd, cm_tag, cm_val,
    output q1_busy, q1_tag, q1_val, q2_busy, q2_tag, q2_val, commit_cnt
  );
endinterface

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with rename-tag table and commit bypass
module reg_rename_file #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int ROB_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  reg_rename_file_if.slave  bus
);
  localparam int NREG = 2 ** REG_W;

  logic [XLEN-1:0]  r_val [NREG];
  logic [ROB_W-1:0] r_tag [NREG];
  logic [NREG-1:0]  r_busy;
  logic [31:0]      r_commit_cnt;

  logic             w_cm_wr;
  logic             w_rn_wr;
  logic [REG_W-1:0] w_idx  [2];
  logic             w_busy [2];
  logic [ROB_W-1:0] w_tag  [2];
  logic [XLEN-1:0]  w_val  [2];

  assign w_cm_wr  = bus.cm_en && (bus.cm_rd != '0);
  assign w_rn_wr  = bus.rn_en && (bus.rn_rd != '0) && !bus.flush;
  assign w_idx[0] = bus.q1_idx;
  assign w_idx[1] = bus.q2_idx;

  // Queries reflect pre-edge state; a matching commit in flight is forwarded directly.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_busy[s] = 1'b0;
      w_tag[s]  = '0;
      w_val[s]  = '0;
      if (r_busy[w_idx[s]]) begin
        if (bus.cm_en && (bus.cm_rd == w_idx[s]) && (bus.cm_tag == r_tag[w_idx[s]])) begin
          w_val[s] = bus.cm_val;
        end else begin
          w_busy[s] = 1'b1;
          w_tag[s]  = r_tag[w_idx[s]];
        end
      end else begin
        w_val[s] = r_val[w_idx[s]];
      end
    end
  end

  assign bus.q1_busy    = w_busy[0];
  assign bus.q1_tag     = w_tag[0];
  assign bus.q1_val     = w_val[0];
  assign bus.q2_busy    = w_busy[1];
  assign bus.q2_tag     = w_tag[1];
  assign bus.q2_val     = w_val[1];
  assign bus.commit_cnt = r_commit_cnt;

  // Rename/flush are applied after commit so they win busy/tag on a same-register collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy       <= '0;
      r_commit_cnt <= '0;
    end else if (bus.rdy) begin
      if (w_cm_wr) begin
        r_val[bus.cm_rd] <= bus.cm_val;
        r_commit_cnt     <= r_commit_cnt + 32'd1;
        if (r_tag[bus.cm_rd] == bus.cm_tag) begin
          r_busy[bus.cm_rd] <= 1'b0;
        end
      end
      if (bus.flush) begin
        r_busy <= '0;
      end else if (w_rn_wr) begin
        r_busy[bus.rn_rd] <= 1'b1;
        r_tag[bus.rn_rd]  <= bus.rn_tag;
      end
    end
  end
endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - self-checking bench for reg_rename_file against an array model
module tb_reg_rename_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_rename_file_if #(.XLEN(32), .REG_W(5), .ROB_W(4)) bus();
  reg_rename_file #(.XLEN(32), .REG_W(5), .ROB_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];
  logic [31:0] m_cnt;

  function automatic logic [36:0] m_query(input logic [4:0] i);
    if (m_busy[i] && bus.cm_en && bus.cm_rd == i && bus.cm_tag == m_tag[i])
      return {1'b0, 4'd0, bus.cm_val};
    if (m_busy[i])
      return {1'b1, m_tag[i], 32'd0};
    return {1'b0, 4'd0, m_val[i]};
  endfunction

  task automatic idle();
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.rn_en = 1'b0; bus.rn_rd = '0; bus.rn_tag = '0;
    bus.cm_en = 1'b0; bus.cm_rd = '0; bus.cm_tag = '0; bus.cm_val = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      m_cnt = '0;
    end else if (bus.rdy) begin
      if (bus.cm_en && bus.cm_rd != 0) begin
        m_val[bus.cm_rd] = bus.cm_val;
        m_cnt = m_cnt + 1;
        if (m_tag[bus.cm_rd] == bus.cm_tag) m_busy[bus.cm_rd] = 1'b0;
      end
      if (bus.flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (bus.rn_en && bus.rn_rd != 0) begin
        m_busy[bus.rn_rd] = 1'b1;
        m_tag[bus.rn_rd]  = bus.rn_tag;
      end
    end
    #1;
  endtask

  task automatic rand_drive();
    bus.rdy    = ($urandom_range(0, 9) != 0);
    bus.flush  = ($urandom_range(0, 19) == 0);
    bus.rn_en  = $urandom_range(0, 1);
    bus.rn_rd  = 5'($urandom);
    bus.rn_tag = 4'($urandom);
    bus.cm_en  = $urandom_range(0, 1);
    bus.cm_rd  = 5'($urandom);
    bus.cm_tag = $urandom_range(0, 1) ? m_tag[bus.cm_rd] : 4'($urandom);
    bus.cm_val = $urandom;
    bus.q1_idx = $urandom_range(0, 1) ? bus.cm_rd : 5'($urandom);
    bus.q2_idx = $urandom_range(0, 1) ? bus.rn_rd : 5'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rand_drive();
      tick();
    end
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.q1_idx = 5'(i);
      bus.q2_idx = 5'(31 - i);
      #1;
      n_cmp++;
      if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== 37'd0 ||
          {bus.q2_busy, bus.q2_tag, bus.q2_val} !== 37'd0) begin
        n_fail++;
        $display("FAIL reset_query reg %0d: q1=%h q2=%h required 0", i,
                 {bus.q1_busy, bus.q1_tag, bus.q1_val}, {bus.q2_busy, bus.q2_tag, bus.q2_val});
      end
    end
    n_cmp++;
    if (bus.commit_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h required 0", bus.commit_cnt);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.rn_en = 1'b1; bus.rn_rd = 5'd5; bus.rn_tag = 4'd3;
    tick();
    idle();
    bus.q1_idx = 5'd5;
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== {1'b1, 4'd3, 32'd0}) begin
      n_fail++;
      $display("FAIL bypass_pending: got %h required %h", {bus.q1_busy, bus.q1_tag, bus.q1_val}, {1'b1, 4'd3, 32'd0});
    end
    bus.cm_en = 1'b1; bus.cm_rd = 5'd5; bus.cm_tag = 4'd3; bus.cm_val = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== {1'b0, 4'd0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL bypass_fwd: got %h required %h", {bus.q1_busy, bus.q1_tag, bus.q1_val}, {1'b0, 4'd0, 32'hDEAD_BEEF});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== {1'b0, 4'd0, 32'hDEAD_BEEF} || bus.commit_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL bypass_stored: got q=%h cnt=%0d required q=%h cnt=1", {bus.q1_busy, bus.q1_tag, bus.q1_val}, bus.commit_cnt, {1'b0, 4'd0, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_younger_rename();
    idle();
    bus.rn_en = 1'b1; bus.rn_rd = 5'd7; bus.rn_tag = 4'd2;
    tick();
    bus.rn_tag = 4'd6;
    tick();
    idle();
    bus.cm_en = 1'b1; bus.cm_rd = 5'd7; bus.cm_tag = 4'd2; bus.cm_val = 32'd11;
    bus.q1_idx = 5'd7;
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== {1'b1, 4'd6, 32'd0}) begin
      n_fail++;
      $display("FAIL younger_nobypass: got %h required %h", {bus.q1_busy, bus.q1_tag, bus.q1_val}, {1'b1, 4'd6, 32'd0});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== {1'b1, 4'd6, 32'd0}) begin
      n_fail++;
      $display("FAIL younger_busy: got %h required %h", {bus.q1_busy, bus.q1_tag, bus.q1_val}, {1'b1, 4'd6, 32'd0});
    end
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== {1'b0, 4'd0, 32'd11}) begin
      n_fail++;
      $display("FAIL younger_val: got %h required %h", {bus.q1_busy, bus.q1_tag, bus.q1_val}, {1'b0, 4'd0, 32'd11});
    end
  endtask

  task automatic test_same_cycle();
    idle();
    bus.rn_en = 1'b1; bus.rn_rd = 5'd9; bus.rn_tag = 4'd4;
    bus.cm_en = 1'b1; bus.cm_rd = 5'd9; bus.cm_tag = 4'd1; bus.cm_val = 32'd5;
    tick();
    idle();
    bus.q2_idx = 5'd9;
    #1;
    n_cmp++;
    if ({bus.q2_busy, bus.q2_tag, bus.q2_val} !== {1'b1, 4'd4, 32'd0}) begin
      n_fail++;
      $display("FAIL same_cycle_busy: got %h required %h", {bus.q2_busy, bus.q2_tag, bus.q2_val}, {1'b1, 4'd4, 32'd0});
    end
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if ({bus.q2_busy, bus.q2_tag, bus.q2_val} !== {1'b0, 4'd0, 32'd5}) begin
      n_fail++;
      $display("FAIL same_cycle_val: got %h required %h", {bus.q2_busy, bus.q2_tag, bus.q2_val}, {1'b0, 4'd0, 32'd5});
    end
  endtask

  task automatic test_flush_x0();
    logic [31:0] cnt_before;
    logic [31:0] x8_before;
    x8_before = m_val[8];
    idle();
    for (int i = 1; i < 32; i++) begin
      bus.rn_en = 1'b1; bus.rn_rd = 5'(i); bus.rn_tag = (i == 3) ? 4'd7 : 4'($urandom);
      tick();
    end
    idle();
    bus.cm_en = 1'b1; bus.cm_rd = 5'd3; bus.cm_tag = 4'd7; bus.cm_val = 32'd42;
    bus.rn_en = 1'b1; bus.rn_rd = 5'd8; bus.rn_tag = 4'd9;
    bus.flush = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      bus.q1_idx = 5'(i);
      #1;
      n_cmp++;
      if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== m_query(5'(i))) begin
        n_fail++;
        $display("FAIL flush_query reg %0d: got %h required %h", i, {bus.q1_busy, bus.q1_tag, bus.q1_val}, m_query(5'(i)));
      end
    end
    bus.q1_idx = 5'd3; bus.q2_idx = 5'd8;
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_val} !== {1'b0, 32'd42} || {bus.q2_busy, bus.q2_val} !== {1'b0, x8_before}) begin
      n_fail++;
      $display("FAIL flush_x3_x8: got x3=%h x8=%h required x3=42 x8=%h", bus.q1_val, bus.q2_val, x8_before);
    end
    cnt_before = m_cnt;
    bus.cm_en = 1'b1; bus.cm_rd = 5'd0; bus.cm_tag = 4'd0; bus.cm_val = 32'd99;
    bus.rn_en = 1'b1; bus.rn_rd = 5'd0; bus.rn_tag = 4'd5;
    bus.q1_idx = 5'd0;
    tick();
    idle();
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== 37'd0 || bus.commit_cnt !== cnt_before) begin
      n_fail++;
      $display("FAIL x0_write: got q=%h cnt=%0d required q=0 cnt=%0d", {bus.q1_busy, bus.q1_tag, bus.q1_val}, bus.commit_cnt, cnt_before);
    end
  endtask

  task automatic test_rdy_wrap();
    idle();
    bus.rdy = 1'b0;
    bus.rn_en = 1'b1; bus.rn_rd = 5'd10; bus.rn_tag = 4'd3;
    bus.cm_en = 1'b1; bus.cm_rd = 5'd11; bus.cm_tag = 4'd0; bus.cm_val = 32'd77;
    tick();
    idle();
    bus.q1_idx = 5'd10; bus.q2_idx = 5'd11;
    #1;
    n_cmp++;
    if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== m_query(5'd10) ||
        {bus.q2_busy, bus.q2_tag, bus.q2_val} !== m_query(5'd11) || bus.commit_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL rdy_freeze: got q1=%h q2=%h cnt=%0d required q1=%h q2=%h cnt=%0d",
               {bus.q1_busy, bus.q1_tag, bus.q1_val}, {bus.q2_busy, bus.q2_tag, bus.q2_val}, bus.commit_cnt,
               m_query(5'd10), m_query(5'd11), m_cnt);
    end
    force dut.r_commit_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_commit_cnt;
    m_cnt = 32'hFFFF_FFFF;
    bus.cm_en = 1'b1; bus.cm_rd = 5'd12; bus.cm_tag = 4'd0; bus.cm_val = 32'd1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.commit_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h required 0", bus.commit_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_drive();
      #1;
      n_cmp++;
      if ({bus.q1_busy, bus.q1_tag, bus.q1_val} !== m_query(bus.q1_idx) ||
          {bus.q2_busy, bus.q2_tag, bus.q2_val} !== m_query(bus.q2_idx) || bus.commit_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL random cycle %0d: q1=%h/%h q2=%h/%h cnt=%0d/%0d (got/required)", c,
                 {bus.q1_busy, bus.q1_tag, bus.q1_val}, m_query(bus.q1_idx),
                 {bus.q2_busy, bus.q2_tag, bus.q2_val}, m_query(bus.q2_idx), bus.commit_cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    bus.q1_idx = '0; bus.q2_idx = '0;
    rst = 1'b0;
    tick();
    tick();
    test_reset();
    test_bypass();
    test_younger_rename();
    test_same_cycle();
    test_flush_x0();
    test_rdy_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
